// File: rtl/snn_cfg_loader.sv
// snn_cfg_loader: byte-stream configuration loader for the two-layer delay SNN.
// Bytes fill a shadow register set. The shadow set is copied to the active
// outputs in a single commit cycle, so the network never sees a partial set.
// Optional feature macro: CFG_CHECKSUM_EN adds a trailing mod-256 checksum byte.
module snn_cfg_loader #(
  parameter int M1 = 20,
  parameter int N1 = 8,
  parameter int N2 = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_start,
  input  logic [7:0]                    cfg_data,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  output logic                          cfg_done,
  output logic                          cfg_error,
  input  logic                          enable,
  output logic                          net_enable,
  output logic [7:0]                    threshold,
  output logic [7:0]                    decay,
  output logic [7:0]                    refractory_period,
  output logic [8*(N1*M1+N2*N1)-1:0]    weights,
  output logic [3*N1*M1-1:0]            delay_values1,
  output logic [N1*M1-1:0]              delays1,
  output logic [3*N2*N1-1:0]            delay_values2,
  output logic [N2*N1-1:0]              delays2
);

  localparam int E1 = N1 * M1;
  localparam int E2 = N2 * N1;
  localparam int E  = E1 + E2;
  localparam int DB = (E + 1) / 2;
  localparam int PB = 3 + E + DB;
  localparam int CW = $clog2(PB + 1);

`ifdef CFG_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_t;
`endif

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            loaded_q, loaded_d;
  logic            accept;
  logic            commit;

  // Shadow set: three scalars, packed weight bytes, and one 4-bit nibble per delay entry
  logic [7:0]      thr_sh_q, thr_sh_d, dec_sh_q, dec_sh_d, ref_sh_q, ref_sh_d;
  logic [8*E-1:0]  w_sh_q, w_sh_d;
  logic [4*E-1:0]  dly_sh_q, dly_sh_d;

  // Active set seen by the network
  logic [7:0]      thr_act_q, thr_act_d, dec_act_q, dec_act_d, ref_act_q, ref_act_d;
  logic [8*E-1:0]  w_act_q, w_act_d;
  logic [4*E-1:0]  dly_act_q, dly_act_d;

`ifdef CFG_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
  logic            err_q, err_d;
`endif

  // A restart in the same cycle as a valid byte drops that byte
  assign accept = cfg_valid && ready_q && !cfg_start;
  assign commit = (state_q == S_COMMIT);

  // Control FSM next-state: byte counter, handshake, commit pulse and loaded flag
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    loaded_d = loaded_q;
`ifdef CFG_CHECKSUM_EN
    sum_d    = sum_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          ready_d = 1'b1;
`ifdef CFG_CHECKSUM_EN
          sum_d   = 8'h00;
          err_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (cfg_start) begin
          cnt_d   = '0;
          ready_d = 1'b1;
`ifdef CFG_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end else if (accept) begin
          cnt_d = cnt_q + CW'(1);
`ifdef CFG_CHECKSUM_EN
          sum_d = 8'(sum_q + cfg_data);
`endif
          if (cnt_q == CW'(PB - 1)) begin
`ifdef CFG_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_COMMIT;
            ready_d = 1'b0;
`endif
          end
        end
      end
`ifdef CFG_CHECKSUM_EN
      S_CHECK: begin
        if (cfg_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          sum_d   = 8'h00;
          ready_d = 1'b1;
        end else if (accept) begin
          ready_d = 1'b0;
          if (8'(sum_q + cfg_data) == 8'h00) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      S_COMMIT: begin
        state_d  = S_IDLE;
        done_d   = 1'b1;
        loaded_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum_q    <= 8'h00;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
`ifdef CFG_CHECKSUM_EN
      sum_q    <= sum_d;
      err_q    <= err_d;
`endif
    end
  end

  // Shadow write decode: each accepted payload byte lands at the slot its index selects
  always_comb begin
    thr_sh_d = thr_sh_q;
    dec_sh_d = dec_sh_q;
    ref_sh_d = ref_sh_q;
    w_sh_d   = w_sh_q;
    dly_sh_d = dly_sh_q;
    if (accept && state_q == S_LOAD) begin
      if (cnt_q == CW'(0)) thr_sh_d = cfg_data;
      if (cnt_q == CW'(1)) dec_sh_d = cfg_data;
      if (cnt_q == CW'(2)) ref_sh_d = cfg_data;
      for (int k = 0; k < E; k++) begin
        if (cnt_q == CW'(3 + k)) w_sh_d[8*k +: 8] = cfg_data;
        if (cnt_q == CW'(3 + E + k / 2))
          dly_sh_d[4*k +: 4] = (k % 2 == 1) ? cfg_data[7:4] : cfg_data[3:0];
      end
    end
  end

  // Shadow registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_sh_q <= 8'h00;
      dec_sh_q <= 8'h00;
      ref_sh_q <= 8'h00;
      w_sh_q   <= '0;
      dly_sh_q <= '0;
    end else begin
      thr_sh_q <= thr_sh_d;
      dec_sh_q <= dec_sh_d;
      ref_sh_q <= ref_sh_d;
      w_sh_q   <= w_sh_d;
      dly_sh_q <= dly_sh_d;
    end
  end

  // Active set updates only in the commit cycle, all fields together
  always_comb begin
    thr_act_d = commit ? thr_sh_q : thr_act_q;
    dec_act_d = commit ? dec_sh_q : dec_act_q;
    ref_act_d = commit ? ref_sh_q : ref_act_q;
    w_act_d   = commit ? w_sh_q   : w_act_q;
    dly_act_d = commit ? dly_sh_q : dly_act_q;
  end

  // Active registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_act_q <= 8'h00;
      dec_act_q <= 8'h00;
      ref_act_q <= 8'h00;
      w_act_q   <= '0;
      dly_act_q <= '0;
    end else begin
      thr_act_q <= thr_act_d;
      dec_act_q <= dec_act_d;
      ref_act_q <= ref_act_d;
      w_act_q   <= w_act_d;
      dly_act_q <= dly_act_d;
    end
  end

  assign cfg_ready         = ready_q;
  assign cfg_done          = done_q;
  assign net_enable        = enable & loaded_q;
  assign threshold         = thr_act_q;
  assign decay             = dec_act_q;
  assign refractory_period = ref_act_q;
  assign weights           = w_act_q;
`ifdef CFG_CHECKSUM_EN
  assign cfg_error         = err_q;
`else
  assign cfg_error         = 1'b0;
`endif

  // Split delay nibbles into value/enable buses per layer
  for (genvar gi = 0; gi < E1; gi++) begin : g_dly1
    assign delay_values1[3*gi +: 3] = dly_act_q[4*gi +: 3];
    assign delays1[gi]              = dly_act_q[4*gi + 3];
  end
  for (genvar gi = 0; gi < E2; gi++) begin : g_dly2
    assign delay_values2[3*gi +: 3] = dly_act_q[4*(E1+gi) +: 3];
    assign delays2[gi]              = dly_act_q[4*(E1+gi) + 3];
  end

endmodule

// File: tb/tb_snn_cfg_loader.sv
// Directed bench for snn_cfg_loader at default sizes (267-byte payload).
module tb_snn_cfg_loader;
  localparam int M1 = 20, N1 = 8, N2 = 2;
  localparam int E1 = N1 * M1, E2 = N2 * N1, E = E1 + E2;
  localparam int DB = (E + 1) / 2, PB = 3 + E + DB;

  logic clk = 1'b0, reset = 1'b1, cfg_start = 1'b0, cfg_valid = 1'b0, enable = 1'b1;
  logic [7:0] cfg_data = 8'h00;
  logic cfg_ready, cfg_done, cfg_error, net_enable;
  logic [7:0] threshold, decay, refractory_period;
  logic [8*E-1:0] weights;
  logic [3*E1-1:0] delay_values1;
  logic [E1-1:0] delays1;
  logic [3*E2-1:0] delay_values2;
  logic [E2-1:0] delays2;

  logic [7:0] stream  [PB];
  logic [7:0] exp_img [PB];
  int vectors = 0, miscompares = 0;

  snn_cfg_loader #(.M1(M1), .N1(N1), .N2(N2)) dut (
    .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_data(cfg_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .enable(enable), .net_enable(net_enable),
    .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
    .weights(weights), .delay_values1(delay_values1), .delays1(delays1),
    .delay_values2(delay_values2), .delays2(delays2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compares every active field against exp_img decoded through the byte map
  task automatic check_active(input string tag);
    int bad;
    logic [7:0] wb, db;
    logic [3:0] enib, anib;
    bad = 0;
    check({tag, "_thr"}, 64'(threshold), 64'(exp_img[0]));
    check({tag, "_dec"}, 64'(decay), 64'(exp_img[1]));
    check({tag, "_ref"}, 64'(refractory_period), 64'(exp_img[2]));
    for (int k = 0; k < E; k++) begin
      wb = weights[8*k +: 8];
      if (wb !== exp_img[3+k]) bad++;
      db = exp_img[3 + E + k/2];
      enib = (k % 2 == 1) ? db[7:4] : db[3:0];
      if (k < E1) anib = {delays1[k], delay_values1[3*k +: 3]};
      else        anib = {delays2[k-E1], delay_values2[3*(k-E1) +: 3]};
      if (anib !== enib) bad++;
    end
    check({tag, "_bad_entries"}, 64'(bad), 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      cfg_valid = 1'b0; cfg_data = 8'($urandom);
      @(posedge clk); #1;
    end
    cfg_valid = 1'b1; cfg_data = d;
    t = 0;
    while (cfg_ready !== 1'b1 && t < 16) begin @(posedge clk); #1; t++; end
    if (t >= 16) check("ready_timeout", 64'(cfg_ready), 64'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0; cfg_data = 8'($urandom);
  endtask

  task automatic send_range(input int lo, input int hi, input int maxgap);
    for (int b = lo; b <= hi; b++)
      send_byte(stream[b], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // Pulses cfg_start; with junk=1 a valid byte is offered in the same cycle and must be dropped
  task automatic begin_load(input bit junk);
    cfg_start = 1'b1;
    if (junk) begin cfg_valid = 1'b1; cfg_data = 8'hEE; end
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_valid = 1'b0;
    check("start_ready", 64'(cfg_ready), 64'd1);
  endtask

  function automatic logic [7:0] checksum();
    logic [7:0] s;
    s = 8'h00;
    for (int b = 0; b < PB; b++) s = 8'(s + stream[b]);
    return 8'(8'h00 - s);
  endfunction

  // Full load of `stream`, checking the old set holds until the commit edge
  task automatic load_full(input string tag, input int maxgap, input bit junk);
    begin_load(junk);
    send_range(0, 130, maxgap);
    check_active({tag, "_midload"});
    send_range(131, PB - 1, maxgap);
`ifdef CFG_CHECKSUM_EN
    check({tag, "_ready_check"}, 64'(cfg_ready), 64'd1);
    check({tag, "_done_pre_ck"}, 64'(cfg_done), 64'd0);
    send_byte(checksum(), 0);
`endif
    check({tag, "_ready_drop"}, 64'(cfg_ready), 64'd0);
    check({tag, "_done_early"}, 64'(cfg_done), 64'd0);
    check_active({tag, "_old_held"});
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(cfg_done), 64'd1);
    exp_img = stream;
    check_active({tag, "_committed"});
    @(posedge clk); #1;
    check({tag, "_done_clear"}, 64'(cfg_done), 64'd0);
    $display("load %s committed", tag);
  endtask

  task automatic fill_random();
    for (int b = 0; b < PB; b++) stream[b] = 8'($urandom);
  endtask

  initial begin
    for (int b = 0; b < PB; b++) exp_img[b] = 8'h00;

    // Reset state with enable high
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_net_enable", 64'(net_enable), 64'd0);
    check("rst_ready", 64'(cfg_ready), 64'd0);
    check("rst_done", 64'(cfg_done), 64'd0);
    check("rst_error", 64'(cfg_error), 64'd0);
    check_active("rst");

    // Idle ignores cfg_valid
    cfg_valid = 1'b1; cfg_data = 8'h55;
    repeat (3) @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("idle_ready", 64'(cfg_ready), 64'd0);

    // Load A from the test plan
    stream[0] = 8'h40; stream[1] = 8'h02; stream[2] = 8'h03;
    for (int k = 0; k < E; k++) stream[3+k] = 8'(k);
    for (int b = 3 + E; b < PB; b++) stream[b] = 8'hA5;
    load_full("A", 0, 1'b0);
    check("A_threshold", 64'(threshold), 64'h40);
    check("A_weight5", 64'(weights[8*5 +: 8]), 64'h05);
    check("A_dv1_0", 64'(delay_values1[2:0]), 64'd5);
    check("A_delays1_0", 64'(delays1[0]), 64'd0);
    check("A_delays1_1", 64'(delays1[1]), 64'd1);
    check("A_delays2_15", 64'(delays2[15]), 64'd1);
    check("A_net_enable", 64'(net_enable), 64'd1);
    enable = 1'b0; #1;
    check("A_net_enable_off", 64'(net_enable), 64'd0);
    enable = 1'b1;

    // Load B with random data and random valid gaps
    fill_random();
    load_full("B", 3, 1'b0);

    // Restart after byte 100: partial C is discarded, D is loaded
    fill_random();
    begin_load(1'b0);
    send_range(0, 100, 1);
    fill_random();
    load_full("D", 1, 1'b1);

`ifdef CFG_CHECKSUM_EN
    // Bad checksum: error, no commit, previous set retained
    fill_random();
    begin_load(1'b0);
    send_range(0, PB - 1, 0);
    send_byte(8'(checksum() + 8'd1), 0);
    check("ck_error_set", 64'(cfg_error), 64'd1);
    check("ck_ready_drop", 64'(cfg_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("ck_no_done", 64'(cfg_done), 64'd0);
      @(posedge clk); #1;
    end
    check_active("ck_retained");
    check("ck_net_enable", 64'(net_enable), 64'd1);
    begin_load(1'b0);
    check("ck_error_cleared", 64'(cfg_error), 64'd0);
    // Correct checksum on the restarted load commits
    fill_random();
    send_range(0, PB - 1, 0);
    send_byte(checksum(), 0);
    check("ck_good_error", 64'(cfg_error), 64'd0);
    @(posedge clk); #1;
    check("ck_good_done", 64'(cfg_done), 64'd1);
    exp_img = stream;
    check_active("ck_good");
`endif

    // Reset asserted at byte 50 aborts and clears everything
    fill_random();
    begin_load(1'b0);
    send_range(0, 49, 0);
    reset = 1'b1; #2;
    for (int b = 0; b < PB; b++) exp_img[b] = 8'h00;
    check("mid_rst_ready", 64'(cfg_ready), 64'd0);
    check("mid_rst_net_enable", 64'(net_enable), 64'd0);
    check("mid_rst_done", 64'(cfg_done), 64'd0);
    check_active("mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    cfg_valid = 1'b1;
    repeat (3) @(posedge clk); #1;
    cfg_valid = 1'b0;
    check("post_rst_ready", 64'(cfg_ready), 64'd0);
    check("post_rst_net_enable", 64'(net_enable), 64'd0);
    check_active("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/snn_cfg_loader.md
# snn_cfg_loader

Parametrised configuration loader for the delay-SNN network top: it receives the threshold, decay, refractory period, weights and delays of both layers as an 8-bit byte stream under a valid/ready handshake. It fills a shadow register set, then commits it atomically to the packed active buses that feed the two-layer network. Layer sizes are parameters. The loaded network is gated off until a first valid configuration has been committed.

## Interface
Parameters:
- M1, 20, layer-1 input count
- N1, 8, layer-1 neuron count
- N2, 2, layer-2 neuron count
- Derived: E1 = N1*M1, E2 = N2*N1, E = E1+E2 (synapse entries); DB = ceil(E/2) (delay bytes); PB = 3+E+DB (payload bytes; 267 at defaults)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- cfg_start  in  1  begin (or restart) a load
- cfg_data  in  8  configuration byte
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  loader accepts a byte
- cfg_done  out  1  one-cycle pulse on commit
- cfg_error  out  1  sticky checksum failure, cleared by cfg_start
- enable  in  1  network run request
- net_enable  out  1  enable gated by a loaded configuration
- threshold, decay, refractory_period  out  8 each  active values
- weights  out  8*E  weights1 in bits [8*E1-1:0], weights2 above them
- delay_values1  out  3*E1;  delays1  out  E1
- delay_values2  out  3*E2;  delays2  out  E2

## Operation
- States: IDLE, LOAD, CHECK (exists only with the macro), COMMIT.
- IDLE: cfg_ready=0; cfg_valid is ignored; cfg_start -> LOAD with the byte counter set to 0.
- LOAD: cfg_ready=1. A byte is accepted when cfg_valid&&cfg_ready, and the counter increments. cfg_start restarts the load at byte 0 and discards the partial shadow contents.
- Byte map by index b:
  - b0 threshold; b1 decay; b2 refractory_period.
  - b3..b3+E-1: weight entry k=b-3 goes to weights[8k+:8]. Layer-1 entry k=n*M1+m (neuron n, input m); layer-2 entries follow the same scheme.
  - Remaining DB bytes: two delay entries per byte, low nibble first. Nibble bits [2:0] = delay value, bit 3 = delay enable. Entries 0..E1-1 go to delay_values1/delays1; entries E1..E-1 go to delay_values2/delays2 with index k-E1. If E is odd, the high nibble of the last byte is ignored.
- After byte PB-1: -> COMMIT (or CHECK with the macro).
- COMMIT: copy shadow to active in one cycle, pulse cfg_done, set the loaded flag, -> IDLE.
- Active outputs never show a partial configuration. The network keeps running on the old set while a load is in progress.
- net_enable = enable & loaded.

## Timing
- Reset: state IDLE; all active/shadow registers 0; loaded=0; cfg_ready=0; cfg_done=0; cfg_error=0; net_enable=0.
- Reset asserted mid-load aborts the load; loaded returns to 0.
- Commit latency: active outputs and cfg_done change on the clock edge one cycle after the edge that accepts the final byte.
- cfg_ready drops in the cycle after the final byte is accepted.
- The handshake tolerates any cfg_valid gaps. cfg_data must be stable only when cfg_valid=1.
- cfg_start in the same cycle as a valid byte: the restart wins and the byte is dropped.

## Configuration
- CFG_CHECKSUM_EN defined:
  - After the payload, one extra byte is accepted in state CHECK.
  - The 8-bit mod-256 sum of all payload bytes plus the checksum byte must equal 0x00. On a match -> COMMIT.
  - On a mismatch: no commit, cfg_error=1, -> IDLE. Active outputs and loaded are unchanged.
- CFG_CHECKSUM_EN undefined: no CHECK state, no checksum byte, and cfg_error is tied to 0.

## Test plan
- Reset, enable=1, no load -> net_enable=0, all active outputs 0, cfg_ready=0.
- Defaults, full load with b0=0x40, b1=0x02, b2=0x03, weight entry k = k[7:0], delay bytes all 0xA5 -> threshold=0x40, weights[8*5+:8]=0x05, delay_values1[2:0]=5, delays1[0]=0, delays1[1]=1, delays2[15]=1; cfg_done pulses once; net_enable=1.
- Random cfg_valid gaps plus a second load with different data -> outputs hold the first set until the commit edge, then switch in one cycle.
- cfg_start asserted after byte 100 and the load repeated -> final outputs reflect only the second stream.
- Reset asserted at byte 50 -> state IDLE, loaded=0, outputs 0; net_enable stays 0 with enable=1.
- With CFG_CHECKSUM_EN: correct checksum -> commit. Checksum off by 1 -> cfg_error=1, no cfg_done, previous outputs retained. Next cfg_start clears cfg_error.
